// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN front-end blocks.
// Holds the line-buffer state encoding and the counter-width derivations.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } lbState_e;

  localparam int DEF_IMG_WIDTH     = 8;
  localparam int DEF_IMG_HEIGHT    = 8;
  localparam int DEF_KERNEL_HEIGHT = 3;
  localparam int DEF_DATA_WIDTH    = 16;

  // A counter over n positions needs at least one bit even when n is 1.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_X_WIDTH = cntWidth(DEF_IMG_WIDTH);
  localparam int DEF_Y_WIDTH = cntWidth(DEF_IMG_HEIGHT);

endpackage

// File: rtl/line_ram.sv
// One image line of pixel storage: single port, asynchronous read, so the
// value seen during a write cycle is the old (pre-write) contents.
module line_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/window_line_buffer.sv
// Raster-to-column converter: buffers KERNEL_HEIGHT-1 lines and emits one
// vertical KERNEL_HEIGHT-pixel column per accepted pixel once enough rows exist.
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
  parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_sof,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] out_col,
  input  logic                                out_ready,
  output logic                                out_sol,
  output logic                                out_eof
);

  localparam int XW = cntWidth(IMG_WIDTH);
  localparam int YW = cntWidth(IMG_HEIGHT);
  localparam int NL = KERNEL_HEIGHT - 1;
  localparam int CW = KERNEL_HEIGHT * DATA_WIDTH;

  localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(KERNEL_HEIGHT - 2);

  lbState_e        state_q, state_d;
  logic [XW-1:0]   xPos_q, xPos_d;
  logic [YW-1:0]   yPos_q, yPos_d;
  logic            outValid_q, outValid_d;
  logic [CW-1:0]   outCol_q, outCol_d;
  logic            outSol_q, outSol_d;
  logic            outEof_q, outEof_d;

  logic            accept;
  logic            active;
  logic            emit;
  logic            rowEnd;
  lbState_e        effState;
  logic [XW-1:0]   effX;
  logic [YW-1:0]   effY;
  logic [CW-1:0]   colD;

  logic [DATA_WIDTH-1:0] lineRd [NL];
  logic [DATA_WIDTH-1:0] lineWr [NL];

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Lines shift upward at the current column: each line takes the next
  // newer line's old value, and the newest line takes the incoming pixel.
  for (genvar k = 0; k < NL; k++) begin : gLine
    if (k == NL - 1) begin : gNewest
      assign lineWr[k] = in_data;
    end else begin : gOlder
      assign lineWr[k] = lineRd[k+1];
    end

    line_ram #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (XW)
    ) uLine (
      .clk     (clk),
      .we_i    (active),
      .addr_i  (effX),
      .wdata_i (lineWr[k]),
      .rdata_o (lineRd[k])
    );
  end

  always_comb begin
    colD = '0;
    for (int k = 0; k < NL; k++) begin
      colD[k*DATA_WIDTH +: DATA_WIDTH] = lineRd[k];
    end
    colD[NL*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  // An accepted sof overrides whatever position we were at and restarts
  // the frame at (0,0) in FILL, regardless of the current state.
  always_comb begin
    effState   = in_sof ? ST_FILL : state_q;
    effX       = in_sof ? '0 : xPos_q;
    effY       = in_sof ? '0 : yPos_q;
    active     = accept && (in_sof || (state_q != ST_IDLE));
    rowEnd     = (effX == X_LAST);
    emit       = active && (effState == ST_STREAM);

    state_d    = state_q;
    xPos_d     = xPos_q;
    yPos_d     = yPos_q;
    outValid_d = outValid_q;
    outCol_d   = outCol_q;
    outSol_d   = outSol_q;
    outEof_d   = outEof_q;

    if (active) begin
      state_d = effState;
      if (rowEnd) begin
        xPos_d = '0;
        yPos_d = (effY == Y_LAST) ? '0 : effY + YW'(1);
        if ((effState == ST_FILL) && (effY == Y_FILL_LAST)) begin
          state_d = ST_STREAM;
        end else if ((effState == ST_STREAM) && (effY == Y_LAST)) begin
          state_d = ST_IDLE;
        end
      end else begin
        xPos_d = effX + XW'(1);
        yPos_d = effY;
      end
    end

    if (emit) begin
      outValid_d = 1'b1;
      outCol_d   = colD;
      outSol_d   = (effX == '0);
      outEof_d   = rowEnd && (effY == Y_LAST);
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      xPos_q     <= '0;
      yPos_q     <= '0;
      outValid_q <= 1'b0;
      outCol_q   <= '0;
      outSol_q   <= 1'b0;
      outEof_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      xPos_q     <= xPos_d;
      yPos_q     <= yPos_d;
      outValid_q <= outValid_d;
      outCol_q   <= outCol_d;
      outSol_q   <= outSol_d;
      outEof_q   <= outEof_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_col   = outCol_q;
  assign out_sol   = outSol_q;
  assign out_eof   = outEof_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: directed frame scenarios plus random traffic,
// checked cycle by cycle against a frame-array reference model.
module tb_window_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KH = 3;
  localparam int DW = 16;
  localparam int CW = KH * DW;
  localparam int COLS_PER_FRAME = W * (H - KH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic          out_ready;
  logic          out_sol;
  logic          out_eof;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] img [H][W];
  bit            mActive;
  int            mx, my;
  bit            expValid, expSol, expEof;
  logic [CW-1:0] expCol;

  logic [CW-1:0] firedCols [$];
  bit            firedSol  [$];
  bit            firedEof  [$];

  always #5 clk = ~clk;

  window_line_buffer #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .KERNEL_HEIGHT (KH),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_ready (out_ready),
    .out_sol   (out_sol),
    .out_eof   (out_eof)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mActive  = 1'b0;
    mx       = 0;
    my       = 0;
    expValid = 1'b0;
    expCol   = '0;
    expSol   = 1'b0;
    expEof   = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit s,
                               input bit r, output bit acc);
    bit            fire;
    bit            produced;
    logic [CW-1:0] col;
    in_valid  = v;
    in_data   = d;
    in_sof    = s;
    out_ready = r;
    #1;
    checkOutput("in_ready", in_ready, !expValid || r);
    acc  = v && (!expValid || r);
    fire = expValid && r;
    if (out_valid && r) begin
      firedCols.push_back(out_col);
      firedSol.push_back(out_sol);
      firedEof.push_back(out_eof);
    end
    produced = 1'b0;
    if (acc) begin
      if (s) begin
        mActive = 1'b1;
        mx = 0;
        my = 0;
      end
      if (mActive) begin
        img[my][mx] = d;
        if (my >= KH - 1) begin
          col = '0;
          for (int k = 0; k < KH; k++) col[k*DW +: DW] = img[my-(KH-1)+k][mx];
          produced = 1'b1;
          expCol   = col;
          expSol   = (mx == 0);
          expEof   = (mx == W - 1) && (my == H - 1);
        end
        if (mx == W - 1) begin
          mx = 0;
          if (my == H - 1) begin
            my = 0;
            mActive = 1'b0;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end
    end
    if (produced) expValid = 1'b1;
    else if (fire) expValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("out_valid", out_valid, expValid);
    if (expValid) begin
      checkOutput("out_col", out_col, expCol);
      checkOutput("out_sol", out_sol, expSol);
      checkOutput("out_eof", out_eof, expEof);
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pix(input int p);
    return DW'(16 * (p / W) + (p % W));
  endfunction

  // Sends one frame of pixel(x,y)=16*y+x; optionally holds out_ready low
  // for three cycles starting at cycle stallAt.
  task automatic sendFrame(input int stallAt);
    int p = 0;
    int cyc = 0;
    bit r;
    bit acc;
    while (p < W * H) begin
      r = !(stallAt >= 0 && cyc >= stallAt && cyc < stallAt + 3);
      applyStimulus(1'b1, pix(p), p == 0, r, acc);
      if (acc) p++;
      cyc++;
    end
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic clearFired();
    firedCols.delete();
    firedSol.delete();
    firedEof.delete();
  endtask

  // Handshaked columns must follow the fixed pixel(x,y)=16*y+x frame layout.
  task automatic checkSeq(input string tag, input int frames);
    int n, x, y;
    logic [CW-1:0] gold;
    checkOutput({tag, "_count"}, firedCols.size(), frames * COLS_PER_FRAME);
    for (int i = 0; i < firedCols.size() && i < frames * COLS_PER_FRAME; i++) begin
      n = i % COLS_PER_FRAME;
      x = n % W;
      y = n / W + KH - 1;
      gold = '0;
      for (int k = 0; k < KH; k++) gold[k*DW +: DW] = DW'(16 * (y - (KH - 1) + k) + x);
      checkOutput({tag, "_col"}, firedCols[i], gold);
      checkOutput({tag, "_sol"}, firedSol[i], x == 0);
      checkOutput({tag, "_eof"}, firedEof[i], (x == W - 1) && (y == H - 1));
    end
    clearFired();
  endtask

  initial begin
    bit acc;
    bit v, s, r;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_col", out_col, '0);
    checkOutput("rst_out_sol", out_sol, 1'b0);
    checkOutput("rst_out_eof", out_eof, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] full frame");
    clearFired();
    sendFrame(-1);
    drain(2);
    checkSeq("frame", 1);

    $display("[TB] output stall mid-stream");
    sendFrame(9);
    drain(2);
    checkSeq("stall", 1);

    $display("[TB] pixels before sof are discarded");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(16'hABC0 + i), 1'b0, 1'b1, acc);
    checkOutput("garbage_no_cols", firedCols.size(), 0);
    sendFrame(-1);
    drain(2);
    checkSeq("garbage", 1);

    $display("[TB] sof restart after six pixels");
    for (int p = 0; p < 6; p++) applyStimulus(1'b1, DW'(16'h5500 + p), p == 0, 1'b1, acc);
    sendFrame(-1);
    drain(2);
    checkSeq("restart", 1);

    $display("[TB] reset while streaming");
    for (int p = 0; p < 9; p++) applyStimulus(1'b1, pix(p), p == 0, 1'b0, acc);
    checkOutput("pre_reset_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    modelReset();
    clearFired();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sendFrame(-1);
    drain(2);
    checkSeq("post_reset", 1);

    $display("[TB] back-to-back frames");
    sendFrame(-1);
    sendFrame(-1);
    drain(2);
    checkSeq("b2b", 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 9) < 7);
      applyStimulus(v, DW'($urandom), s, r, acc);
    end
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
